// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: accepts a binary value over a load/ready handshake and
// converts it to BCD serially (shift-add-3). It scans the digits onto one
// shared 7-segment bus, with optional leading-zero blanking and overflow dashes.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BIN_W-1:0]  value,
    output logic              ready,
    output logic [DIGITS-1:0] digit_en,
    output logic [6:0]        segments,
    output logic              overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    // Segment pattern {a..g} for one decimal digit; codes 10..15 cannot occur.
    function automatic logic [6:0] digit_seg(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Conversion side.
    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [BCD_W-1:0] disp_q, disp_d;
    logic             ovf_q, ovf_d;

    // Scan side.
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] en_q, en_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] blank;
    logic              zero_run;
    logic [3:0]        nib;

    // Handshake FSM with the double-dabble datapath and the display commit.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        ready   = 1'b0;

        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    bin_d = value;
                    bcd_d = '0;
                    cnt_d = '0;
                    if (32'(value) > MAX_VAL) begin
                        pend_d  = 1'b1;
                        state_d = COMMIT;
                    end else begin
                        pend_d  = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                disp_d  = bcd_q;
                ovf_d   = pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Conversion and display registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            // NOTE: the display register is reset, not left to power-up, so the first scan shows 0.
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every register samples the pre-edge values.
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    // Leading-zero mask: digit i>0 is blank when it and every higher digit are zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_q[4*i +: 4] == 4'd0);
            if (i > 0 && BLANK_LZ != 0) begin
                blank[i] = zero_run;
            end
        end
    end

    // Prescaler and digit rotation; the select and the pattern are computed for the same new index.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        en_d  = en_q;
        seg_d = seg_q;
        nib   = '0;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            en_d  = DIGITS'(1) << idx_d;
            nib   = disp_q[4*int'(idx_d) +: 4];
            if (ovf_q) begin
                seg_d = SEG_DASH;
            end else if (blank[idx_d]) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = digit_seg(nib);
            end
        end
    end

    // Scan registers; digit_en and segments always move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            en_q  <= DIGITS'(1);
            seg_q <= SEG_ZERO;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            en_q  <= en_d;
            seg_q <= seg_d;
        end
    end

    assign digit_en = en_q;
    assign segments = seg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (blanking on/off) share the stimulus.
// Expected digit patterns are queued per load and checked as the scan reaches each digit.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int BIN_W    = 14;
    localparam int SCAN_DIV = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             load  = 1'b0;
    logic [BIN_W-1:0] value = '0;

    logic             ready_b, ready_n, ovf_b, ovf_n;
    logic [3:0]       en_b, en_n;
    logic [6:0]       seg_b, seg_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg_b;
        logic [6:0] seg_n;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .ready(ready_b), .digit_en(en_b), .segments(seg_b), .overflow(ovf_b)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .ready(ready_n), .digit_en(en_n), .segments(seg_n), .overflow(ovf_n)
    );

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            8:       return 7'b1111111;
            9:       return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Queue the four expected digit slots for a displayed value.
    task automatic push_expect(input int v);
        int   d[DIGITS];
        int   rem;
        int   msd;
        exp_t e;
        rem = v;
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = rem % 10;
            rem  = rem / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            e.en = 4'(1 << i);
            if (v > 9999) begin
                e.seg_b = 7'b0000001;
                e.seg_n = 7'b0000001;
                e.ovf   = 1'b1;
            end else begin
                e.seg_b = (i > msd) ? 7'b0000000 : ref_seg(d[i]);
                e.seg_n = ref_seg(d[i]);
                e.ovf   = 1'b0;
            end
            sb.push_back(e);
        end
    endtask

    // Let every digit refresh, then pop each expected slot when the scan reaches it.
    task automatic drain(input string tag);
        exp_t e;
        int   waited;
        repeat (DIGITS * SCAN_DIV + 2) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            waited = 0;
            while (en_b !== e.en && waited < 2 * DIGITS * SCAN_DIV) begin
                @(posedge clk);
                #1;
                waited++;
            end
            checks++;
            if (en_b !== e.en) begin
                errors++;
                $display("FAIL %s scan_timeout: digit_en=%b required %b", tag, en_b, e.en);
            end else begin
                checks++;
                if (seg_b !== e.seg_b) begin
                    errors++;
                    $display("FAIL %s seg_blank[%b]: got %b required %b", tag, e.en, seg_b, e.seg_b);
                end
                checks++;
                if (seg_n !== e.seg_n) begin
                    errors++;
                    $display("FAIL %s seg_noblank[%b]: got %b required %b", tag, e.en, seg_n, e.seg_n);
                end
                checks++;
                if (en_n !== e.en) begin
                    errors++;
                    $display("FAIL %s en_noblank: got %b required %b", tag, en_n, e.en);
                end
                checks++;
                if (ovf_b !== e.ovf || ovf_n !== e.ovf) begin
                    errors++;
                    $display("FAIL %s overflow[%b]: got %b/%b required %b", tag, e.en, ovf_b, ovf_n, e.ovf);
                end
            end
        end
    endtask

    // Pulse load for one edge, then count sampled cycles with ready low.
    task automatic do_load(input int v, output int low);
        @(negedge clk);
        load  = 1'b1;
        value = BIN_W'(v);
        @(posedge clk);
        #1;
        load = 1'b0;
        low  = 0;
        while (ready_b !== 1'b1 && low < 100) begin
            low++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_b !== 1'b1 || ovf_b !== 1'b0 || en_b !== 4'b0001 || seg_b !== 7'b1111110) begin
            errors++;
            $display("FAIL reset_values: ready=%b ovf=%b en=%b seg=%b required 1 0 0001 1111110",
                     ready_b, ovf_b, en_b, seg_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_en  = 4'(1 << ((k / 4) % 4));
            exp_seg = (((k / 4) % 4) == 0) ? 7'b1111110 : 7'b0000000;
            checks++;
            if (en_b !== exp_en || seg_b !== exp_seg) begin
                errors++;
                $display("FAIL reset_rotation edge %0d: en=%b seg=%b required en=%b seg=%b",
                         k, en_b, seg_b, exp_en, exp_seg);
            end
        end
        push_expect(0);
        drain("reset");
    endtask

    task automatic test_load_59();
        int low;
        do_load(59, low);
        checks++;
        if (low !== 15) begin
            errors++;
            $display("FAIL load59_latency: ready low %0d cycles required 15", low);
        end
        push_expect(59);
        drain("load59");
    endtask

    task automatic test_overflow();
        int low;
        do_load(10000, low);
        checks++;
        if (low !== 1 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL overflow_commit: low=%0d ovf=%b required 1 1", low, ovf_b);
        end
        push_expect(10000);
        drain("ovf10000");
        do_load(9999, low);
        checks++;
        if (low !== 15 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: low=%0d ovf=%b required 15 0", low, ovf_b);
        end
        push_expect(9999);
        drain("max9999");
    endtask

    task automatic test_load_ignored();
        int low;
        low = 0;
        @(negedge clk);
        load  = 1'b1;
        value = BIN_W'(1234);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            load = (c == 4);
            if (c == 4) value = BIN_W'(42);
            if (ready_b === 1'b1) break;
            low++;
        end
        load = 1'b0;
        checks++;
        if (low !== 15) begin
            errors++;
            $display("FAIL busy_load_latency: ready low %0d cycles required 15", low);
        end
        push_expect(1234);
        drain("busy_load");
    endtask

    task automatic test_zero_blanking();
        int low;
        do_load(0, low);
        checks++;
        if (low !== 15) begin
            errors++;
            $display("FAIL zero_latency: ready low %0d cycles required 15", low);
        end
        push_expect(0);
        drain("zero");
        do_load(1005, low);
        push_expect(1005);
        drain("inner_zeros");
    endtask

    task automatic test_reset_mid_conv();
        int low;
        do_load(59, low);
        push_expect(59);
        drain("pre_abort");
        @(negedge clk);
        load  = 1'b1;
        value = BIN_W'(8191);
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_b !== 1'b1 || ovf_b !== 1'b0 || en_b !== 4'b0001 ||
            seg_b !== 7'b1111110 || seg_n !== 7'b1111110) begin
            errors++;
            $display("FAIL abort_reset_values: ready=%b ovf=%b en=%b seg=%b/%b required 1 0 0001 1111110",
                     ready_b, ovf_b, en_b, seg_b, seg_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (ready_b !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b required 1", ready_b);
        end
        push_expect(0);
        drain("abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_59();
        test_overflow();
        test_load_ignored();
        test_zero_blanking();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
